// File: rtl/dm_store.sv
// M-stage data memory: byte/halfword/word stores with lane merging into a word RAM,
// combinational aligned read, store address exception decode and commit-trace registers.
module dm_store #(
    parameter int unsigned DEPTH_WORDS = 3072,
    parameter int unsigned IDX_W       = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic        we,
    input  logic        flush,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] dout,
    output logic        st_exp,
    output logic        dm_hit,
    output logic [31:0] last_addr,
    output logic [31:0] last_data,
    output logic [31:0] wr_count
);

    localparam logic [5:0]  OpSb    = 6'b101000;
    localparam logic [5:0]  OpSh    = 6'b101001;
    localparam logic [5:0]  OpSw    = 6'b101011;
    localparam logic [31:0] RamLast = 32'((DEPTH_WORDS * 4) - 1);

    logic [31:0]      mem_q [DEPTH_WORDS];
    logic [31:0]      last_addr_q, last_data_q, wr_count_q;
    logic [IDX_W-1:0] idx;
    logic             is_sb, is_sh, is_sw, store_op;
    logic             ram, dev, illegal, commit;
    logic [31:0]      old_word, new_word;

    assign idx      = addr[IDX_W+1:2];
    assign is_sb    = (op == OpSb);
    assign is_sh    = (op == OpSh);
    assign is_sw    = (op == OpSw);
    assign store_op = is_sb | is_sh | is_sw;

    assign ram     = (addr <= RamLast);
    assign dev     = ((addr >= 32'h0000_7F00) && (addr <= 32'h0000_7F0B)) ||
                     ((addr >= 32'h0000_7F10) && (addr <= 32'h0000_7F1B));
    assign illegal = !ram && !dev;

    assign st_exp = we && store_op &&
                    ((is_sh && addr[0]) || (is_sw && (addr[1:0] != 2'b00)) ||
                     illegal || (dev && !is_sw));
    assign dm_hit = ram;

    // Device-range stores are left to the bridge, so only RAM stores commit.
    assign commit = we && store_op && ram && !st_exp && !flush;

    always_comb begin
        old_word = '0;
        if (ram) begin
            old_word = mem_q[idx];
        end
    end

    always_comb begin
        dout = '0;
        if (!reset) begin
            dout = old_word;
        end
    end

    always_comb begin
        new_word = old_word;
        case (op)
            OpSw: new_word = wdata;
            OpSh: begin
                if (addr[1]) begin
                    new_word[31:16] = wdata[15:0];
                end else begin
                    new_word[15:0] = wdata[15:0];
                end
            end
            OpSb: new_word[{addr[1:0], 3'b000} +: 8] = wdata[7:0];
            default: new_word = old_word;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
                mem_q[i] <= '0;
            end
            last_addr_q <= '0;
            last_data_q <= '0;
            wr_count_q  <= '0;
        end else if (commit) begin
            mem_q[idx]  <= new_word;
            last_addr_q <= {addr[31:2], 2'b00};
            last_data_q <= new_word;
            wr_count_q  <= wr_count_q + 32'd1;
        end
    end

    assign last_addr = last_addr_q;
    assign last_data = last_data_q;
    assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_dm_store.sv
// Scoreboard bench for dm_store: a byte-array reference model predicts every cycle's
// outputs, a driver queues the predictions and a negedge monitor compares them.
module tb_dm_store;

    localparam logic [5:0] OpSb = 6'b101000;
    localparam logic [5:0] OpSh = 6'b101001;
    localparam logic [5:0] OpSw = 6'b101011;
    localparam logic [5:0] OpLw = 6'b100011;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  op = '0;
    logic        we = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] dout, last_addr, last_data, wr_count;
    logic        st_exp, dm_hit;

    dm_store dut (
        .clk      (clk),
        .reset    (reset),
        .op       (op),
        .we       (we),
        .flush    (flush),
        .addr     (addr),
        .wdata    (wdata),
        .dout     (dout),
        .st_exp   (st_exp),
        .dm_hit   (dm_hit),
        .last_addr(last_addr),
        .last_data(last_data),
        .wr_count (wr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] dout;
        logic        st_exp;
        logic        dm_hit;
        logic [31:0] last_addr;
        logic [31:0] last_data;
        logic [31:0] wr_count;
        int          seq;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          seq_no = 0;

    // Reference model: memory held as individual bytes, little-endian within a word.
    logic [7:0]  bmem [12288];
    logic [31:0] m_la = '0, m_ld = '0, m_cnt = '0;

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        int base = int'({a[31:2], 2'b00});
        return {bmem[base+3], bmem[base+2], bmem[base+1], bmem[base]};
    endfunction

    task automatic chk(input string nm, input int sq, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s seq=%0d got=%h want=%h", nm, sq, act, req);
        end
    endtask

    task automatic issue(input logic [5:0] o, input logic w, input logic f,
                         input logic [31:0] a, input logic [31:0] d, input logic r);
        int   size;
        logic is_store, in_ram, in_dev, exc, commit;
        exp_t e;
        @(posedge clk);
        #1;
        reset = r; op = o; we = w; flush = f; addr = a; wdata = d;
        if (r) begin
            foreach (bmem[i]) bmem[i] = 8'h00;
            m_la = '0; m_ld = '0; m_cnt = '0;
        end
        is_store = (o == OpSb) || (o == OpSh) || (o == OpSw);
        size     = (o == OpSw) ? 4 : (o == OpSh) ? 2 : 1;
        in_ram   = (a < 32'h3000);
        in_dev   = (a >= 32'h7F00 && a < 32'h7F0C) || (a >= 32'h7F10 && a < 32'h7F1C);
        exc      = w && is_store &&
                   (((a % size) != 0) || !(in_ram || (in_dev && size == 4)));
        commit   = w && is_store && in_ram && !exc && !f && !r;
        e.dout      = in_ram ? rd_word(a) : 32'h0;
        e.st_exp    = exc;
        e.dm_hit    = in_ram;
        e.last_addr = m_la;
        e.last_data = m_ld;
        e.wr_count  = m_cnt;
        e.seq       = seq_no++;
        sb_q.push_back(e);
        if (commit) begin
            for (int k = 0; k < size; k++) begin
                bmem[int'(a) + k] = d[8*k +: 8];
            end
            m_la  = a & 32'hFFFF_FFFC;
            m_ld  = rd_word(a);
            m_cnt = m_cnt + 1;
        end
    endtask

    task automatic rand_issue(input logic r);
        logic [31:0] a;
        logic [5:0]  o;
        case ($urandom_range(0, 5))
            0, 1:    a = 32'($urandom_range(0, 32'h3F));
            2:       a = 32'($urandom_range(32'h2FF0, 32'h3007));
            3:       a = 32'($urandom_range(32'h7EFC, 32'h7F1F));
            4:       a = $urandom;
            default: a = 32'($urandom_range(0, 32'h2FFF));
        endcase
        case ($urandom_range(0, 7))
            0, 1:    o = OpSb;
            2, 3:    o = OpSh;
            4, 5:    o = OpSw;
            6:       o = OpLw;
            default: o = 6'($urandom);
        endcase
        issue(o, $urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0, a, $urandom, r);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("dout", e.seq, dout, e.dout);
            chk("st_exp", e.seq, 32'(st_exp), 32'(e.st_exp));
            chk("dm_hit", e.seq, 32'(dm_hit), 32'(e.dm_hit));
            chk("last_addr", e.seq, last_addr, e.last_addr);
            chk("last_data", e.seq, last_data, e.last_data);
            chk("wr_count", e.seq, wr_count, e.wr_count);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        foreach (bmem[i]) bmem[i] = 8'h00;
        issue(OpLw, 1'b0, 1'b0, 32'h10, 32'h0, 1'b1);
        // Directed walk-through of the basic store, merge, exception and boundary cases.
        issue(OpSw, 1'b1, 1'b0, 32'h0010, 32'h1234_5678, 1'b0);
        issue(OpLw, 1'b0, 1'b0, 32'h0010, 32'h0, 1'b0);
        issue(OpSb, 1'b1, 1'b0, 32'h0011, 32'h0000_00AB, 1'b0);
        issue(OpSh, 1'b1, 1'b0, 32'h0012, 32'h0000_BEEF, 1'b0);
        issue(OpLw, 1'b0, 1'b0, 32'h0010, 32'h0, 1'b0);
        issue(OpSh, 1'b1, 1'b0, 32'h0013, 32'hDEAD_BEEF, 1'b0);
        issue(OpSw, 1'b1, 1'b0, 32'h0016, 32'hDEAD_BEEF, 1'b0);
        issue(OpSw, 1'b1, 1'b0, 32'h7F04, 32'h5555_5555, 1'b0);
        issue(OpSb, 1'b1, 1'b0, 32'h7F04, 32'h5555_5555, 1'b0);
        issue(OpSw, 1'b1, 1'b0, 32'h3000, 32'h5555_5555, 1'b0);
        issue(OpSw, 1'b1, 1'b0, 32'h2FFC, 32'h0102_0304, 1'b0);
        issue(OpSb, 1'b1, 1'b0, 32'h2FFF, 32'h0000_005A, 1'b0);
        issue(OpLw, 1'b0, 1'b0, 32'h2FFC, 32'h0, 1'b0);
        issue(OpSw, 1'b1, 1'b1, 32'h0020, 32'hFFFF_FFFF, 1'b0);
        issue(OpLw, 1'b0, 1'b0, 32'h0020, 32'h0, 1'b0);
        issue(OpLw, 1'b1, 1'b0, 32'h0024, 32'hFFFF_FFFF, 1'b0);
        for (int i = 0; i < 600; i++) rand_issue(1'b0);
        // Reset raised between edges; the store alongside it must not commit.
        issue(OpSw, 1'b1, 1'b0, 32'h0010, 32'hCAFE_F00D, 1'b1);
        issue(OpSw, 1'b1, 1'b0, 32'h0014, 32'h1111_2222, 1'b1);
        issue(OpLw, 1'b0, 1'b0, 32'h0010, 32'h0, 1'b0);
        issue(OpLw, 1'b0, 1'b0, 32'h0014, 32'h0, 1'b0);
        for (int i = 0; i < 600; i++) rand_issue($urandom_range(0, 99) == 0);
        issue(OpLw, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("drain", -1, 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dm_store.md
Name: dm_store

Overview:
- Data memory for the MIPS pipeline M stage; directly upstream of the load-extension stage.
- Performs byte, halfword and word stores with lane merging into a word-addressed RAM.
- Presents the raw aligned read word (DM_Out) combinationally to the load-extension stage.
- Flags store address exceptions and keeps registered commit-trace state for the bench.

Parameters:
- DEPTH_WORDS, 3072, number of 32-bit words; byte range 0x0000_0000–0x0000_2FFF.
- IDX_W, 12, word-index width taken from addr[IDX_W+1:2].

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- op  in  6  M-stage opcode (instr[31:26]); sb=101000, sh=101001, sw=101011.
- we  in  1  M-stage MemWrite from control.
- flush  in  1  exception/interrupt taken this cycle; suppresses the store commit.
- addr  in  32  byte address (ALU_Out_M).
- wdata  in  32  store data (forwarded rt value).
- dout  out  32  aligned read word, combinational.
- st_exp  out  1  store address exception, combinational.
- dm_hit  out  1  addr lies in RAM range, combinational.
- last_addr  out  32  registered word-aligned address of the last committed store.
- last_data  out  32  registered merged word written by the last committed store.
- wr_count  out  32  registered count of committed stores.

Behaviour:
- Range decode
  - ram = (addr <= 0x2FFF).
  - dev = addr in 0x7F00–0x7F0B or 0x7F10–0x7F1B.
  - Every other address is illegal.
- st_exp = we && store_op && (sh && addr[0], or sw && addr[1:0]!=0, or illegal address, or dev && !sw).
  - Non-store ops never raise st_exp.
- dm_hit = ram.
- dout = mem[addr[13:2]] when ram, else 32'h0. Read is asynchronous and zero-latency, so it is valid in the same cycle the load-extension stage consumes it.
- Commit condition: commit = we && store_op && ram && !st_exp && !flush.
  - On the rising edge with commit, exactly one word is written.
  - Device-range sw: no RAM write and no commit; the bridge handles it.
- Lane merge, with old = current mem word:
  - sw: new = wdata.
  - sh: addr[1]=0 writes lanes [15:0]; addr[1]=1 writes [31:16]; both take wdata[15:0]. Other lanes are kept.
  - sb: lane k = addr[1:0] gets wdata[7:0]; other lanes are kept.
- Trace registers on commit:
  - last_addr <= {addr[31:2],2'b00}.
  - last_data <= new.
  - wr_count <= wr_count+1; it wraps from 0xFFFF_FFFF to 0.
- Store then load to the same word: the next cycle's dout reflects the new word (write at edge N, visible after edge N). A same-cycle read returns the old word.
- Reset (asynchronous, any time, including mid-store)
  - All memory words, last_addr, last_data and wr_count go to 0 immediately.
  - No write occurs on an edge while reset is high.
  - dout reads 0 while in reset.
  - st_exp and dm_hit stay combinational functions of the inputs.
- flush with a valid store: no write and no counter change; st_exp is still reported.
- we with a non-store op (defensive): treated as no store.
- Boundaries:
  - addr = 0x2FFC with sw is legal.
  - addr = 0x3000 with sw is illegal, so st_exp = 1.
  - addr = 0x2FFF with sb is legal and writes lane 3 of the last word.

Test Plan:
- Reset, then sw addr=0x0010 wdata=0x12345678 → after edge: mem[4]=0x12345678; dout@0x0010=0x12345678; wr_count=1; last_addr=0x10.
- Over that word, sb addr=0x0011 wdata=0xAB, then sh addr=0x0012 wdata=0xBEEF → dout=0xBEEFAB78 after the second edge; wr_count=3; last_data=0xBEEFAB78.
- sh addr=0x0013 and sw addr=0x0016 → st_exp=1 on each; memory unchanged; wr_count unchanged.
- sw addr=0x7F04 → st_exp=0, dm_hit=0, no write. sb addr=0x7F04 → st_exp=1. sw addr=0x3000 → st_exp=1. sb addr=0x2FFF wdata=0x5A → mem[3071][31:24]=0x5A.
- sw addr=0x20 wdata=0xFFFFFFFF with flush=1 → no write; dout@0x20=0; wr_count unchanged.
- Assert reset asynchronously between edges after several stores → all outputs and memory read 0 immediately. A store presented on the same edge that reset is high is not committed; wr_count=0 after release.
